// File: rtl/rs_param_age.sv
// Age-ordered reservation station: holds dispatched ALU ops until both operands
// are ready, wakes operands from NUM_CDB broadcast channels and issues the oldest ready op.
module rs_param_age #(
    parameter int DEPTH   = 16,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4,
    parameter int TYPE_W  = 6,
    parameter int NUM_CDB = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    output logic                      full_out,
    input  logic                      disp_valid,
    input  logic [TYPE_W-1:0]         disp_type,
    input  logic [DATA_W-1:0]         disp_pc,
    input  logic [DATA_W-1:0]         disp_imm,
    input  logic [ROB_W-1:0]          disp_rob,
    input  logic                      disp_rdy_j,
    input  logic                      disp_rdy_k,
    input  logic [DATA_W-1:0]         disp_v_j,
    input  logic [DATA_W-1:0]         disp_v_k,
    input  logic [ROB_W-1:0]          disp_q_j,
    input  logic [ROB_W-1:0]          disp_q_k,
    input  logic                      issue_stall,
    output logic                      issue_valid,
    output logic [TYPE_W-1:0]         issue_type,
    output logic [DATA_W-1:0]         issue_pc,
    output logic [DATA_W-1:0]         issue_imm,
    output logic [DATA_W-1:0]         issue_rs1,
    output logic [DATA_W-1:0]         issue_rs2,
    output logic [ROB_W-1:0]          issue_rob,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]  cdb_rob,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_value
);

    localparam int IW = $clog2(DEPTH);

    // Returns {hit, value} for a tag; the lowest matching channel wins.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [ROB_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*ROB_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            res = (vld[c] && (tags[c*ROB_W +: ROB_W] == tag)) ?
                  {1'b1, vals[c*DATA_W +: DATA_W]} : res;
        end
        return res;
    endfunction

    logic [DEPTH-1:0]  busy_r;
    logic [DEPTH-1:0]  rdy_j_r;
    logic [DEPTH-1:0]  rdy_k_r;
    logic [TYPE_W-1:0] type_r  [DEPTH];
    logic [DATA_W-1:0] pc_r    [DEPTH];
    logic [DATA_W-1:0] imm_r   [DEPTH];
    logic [ROB_W-1:0]  rob_r   [DEPTH];
    logic [DATA_W-1:0] v_j_r   [DEPTH];
    logic [DATA_W-1:0] v_k_r   [DEPTH];
    logic [ROB_W-1:0]  q_j_r   [DEPTH];
    logic [ROB_W-1:0]  q_k_r   [DEPTH];
    // older_r[i][j] set means entry i was allocated before entry j
    logic [DEPTH-1:0]  older_r [DEPTH];

    logic              issue_valid_r;
    logic [TYPE_W-1:0] issue_type_r;
    logic [DATA_W-1:0] issue_pc_r;
    logic [DATA_W-1:0] issue_imm_r;
    logic [DATA_W-1:0] issue_rs1_r;
    logic [DATA_W-1:0] issue_rs2_r;
    logic [ROB_W-1:0]  issue_rob_r;

    logic [DATA_W:0]   lk_j_s [DEPTH];
    logic [DATA_W:0]   lk_k_s [DEPTH];
    logic [DATA_W:0]   dlk_j_s;
    logic [DATA_W:0]   dlk_k_s;
    logic [DEPTH-1:0]  ready_s;
    logic [DEPTH-1:0]  blocked_s;
    logic [DEPTH-1:0]  sel_oh_s;
    logic              any_ready_s;
    logic [IW-1:0]     sel_idx_s;
    logic [IW-1:0]     alloc_idx_s;
    logic              disp_acc_s;
    logic              issue_en_s;

    assign full_out    = &busy_r;
    assign disp_acc_s  = disp_valid && !full_out;
    assign issue_en_s  = !issue_stall || !issue_valid_r;

    assign issue_valid = issue_valid_r;
    assign issue_type  = issue_type_r;
    assign issue_pc    = issue_pc_r;
    assign issue_imm   = issue_imm_r;
    assign issue_rs1   = issue_rs1_r;
    assign issue_rs2   = issue_rs2_r;
    assign issue_rob   = issue_rob_r;

    // CDB tag compare for every stored operand and for the incoming dispatch.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            lk_j_s[i] = cdb_lookup(q_j_r[i], cdb_valid, cdb_rob, cdb_value);
            lk_k_s[i] = cdb_lookup(q_k_r[i], cdb_valid, cdb_rob, cdb_value);
        end
        dlk_j_s = cdb_lookup(disp_q_j, cdb_valid, cdb_rob, cdb_value);
        dlk_k_s = cdb_lookup(disp_q_k, cdb_valid, cdb_rob, cdb_value);
    end

    // Oldest-ready select from the age matrix and lowest-free allocation.
    always_comb begin
        ready_s     = '0;
        blocked_s   = '0;
        sel_oh_s    = '0;
        sel_idx_s   = '0;
        alloc_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_s[i] = busy_r[i] & rdy_j_r[i] & rdy_k_r[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                blocked_s[i] = blocked_s[i] | (ready_s[j] & older_r[j][i]);
            end
            sel_oh_s[i] = ready_s[i] & ~blocked_s[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            sel_idx_s = sel_oh_s[i] ? IW'(i) : sel_idx_s;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            alloc_idx_s = !busy_r[i] ? IW'(i) : alloc_idx_s;
        end
        any_ready_s = |ready_s;
    end

    // Entry storage: wakeup, issue release, dispatch allocation and age update.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_r  <= '0;
            rdy_j_r <= '0;
            rdy_k_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_r[i]  <= '0;
                pc_r[i]    <= '0;
                imm_r[i]   <= '0;
                rob_r[i]   <= '0;
                v_j_r[i]   <= '0;
                v_k_r[i]   <= '0;
                q_j_r[i]   <= '0;
                q_k_r[i]   <= '0;
                older_r[i] <= '0;
            end
        end else if (flush_in) begin
            busy_r <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_r[i] && !rdy_j_r[i] && lk_j_s[i][DATA_W]) begin
                    rdy_j_r[i] <= 1'b1;
                    v_j_r[i]   <= lk_j_s[i][DATA_W-1:0];
                end
                if (busy_r[i] && !rdy_k_r[i] && lk_k_s[i][DATA_W]) begin
                    rdy_k_r[i] <= 1'b1;
                    v_k_r[i]   <= lk_k_s[i][DATA_W-1:0];
                end
            end
            if (issue_en_s && any_ready_s) begin
                busy_r[sel_idx_s] <= 1'b0;
            end
            if (disp_acc_s) begin
                busy_r[alloc_idx_s]  <= 1'b1;
                type_r[alloc_idx_s]  <= disp_type;
                pc_r[alloc_idx_s]    <= disp_pc;
                imm_r[alloc_idx_s]   <= disp_imm;
                rob_r[alloc_idx_s]   <= disp_rob;
                q_j_r[alloc_idx_s]   <= disp_q_j;
                q_k_r[alloc_idx_s]   <= disp_q_k;
                rdy_j_r[alloc_idx_s] <= disp_rdy_j | dlk_j_s[DATA_W];
                rdy_k_r[alloc_idx_s] <= disp_rdy_k | dlk_k_s[DATA_W];
                v_j_r[alloc_idx_s]   <= (!disp_rdy_j && dlk_j_s[DATA_W]) ?
                                        dlk_j_s[DATA_W-1:0] : disp_v_j;
                v_k_r[alloc_idx_s]   <= (!disp_rdy_k && dlk_k_s[DATA_W]) ?
                                        dlk_k_s[DATA_W-1:0] : disp_v_k;
                older_r[alloc_idx_s] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    older_r[j][alloc_idx_s] <= busy_r[j];
                end
            end
        end
    end

    // Issue register: loads the selected entry unless the ALU stalls a held op.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            issue_valid_r <= 1'b0;
            issue_type_r  <= '0;
            issue_pc_r    <= '0;
            issue_imm_r   <= '0;
            issue_rs1_r   <= '0;
            issue_rs2_r   <= '0;
            issue_rob_r   <= '0;
        end else if (flush_in) begin
            issue_valid_r <= 1'b0;
        end else if (rdy_in && issue_en_s) begin
            issue_valid_r <= any_ready_s;
            if (any_ready_s) begin
                issue_type_r <= type_r[sel_idx_s];
                issue_pc_r   <= pc_r[sel_idx_s];
                issue_imm_r  <= imm_r[sel_idx_s];
                issue_rs1_r  <= v_j_r[sel_idx_s];
                issue_rs2_r  <= v_k_r[sel_idx_s];
                issue_rob_r  <= rob_r[sel_idx_s];
            end
        end
    end

endmodule

// File: tb/tb_rs_param_age.sv
// Bench for rs_param_age: constant vector table, directed multi-cycle sequences and
// randomized traffic against an age-ordered queue model of the reservation station.
module tb_rs_param_age;

    localparam int DEPTH = 16, DATA_W = 32, ROB_W = 4, TYPE_W = 6, NUM_CDB = 2;

    logic              clk_in = 1'b0;
    logic              rst_n_in, rdy_in, flush_in, full_out;
    logic              disp_valid, disp_rdy_j, disp_rdy_k;
    logic [TYPE_W-1:0] disp_type;
    logic [31:0]       disp_pc, disp_imm, disp_v_j, disp_v_k;
    logic [3:0]        disp_rob, disp_q_j, disp_q_k;
    logic              issue_stall, issue_valid;
    logic [TYPE_W-1:0] issue_type;
    logic [31:0]       issue_pc, issue_imm, issue_rs1, issue_rs2;
    logic [3:0]        issue_rob;
    logic [1:0]        cdb_valid;
    logic [7:0]        cdb_rob;
    logic [63:0]       cdb_value;

    int checks   = 0;
    int failures = 0;

    rs_param_age #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .TYPE_W(TYPE_W), .NUM_CDB(NUM_CDB)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in), .full_out(full_out),
        .disp_valid(disp_valid), .disp_type(disp_type), .disp_pc(disp_pc), .disp_imm(disp_imm),
        .disp_rob(disp_rob), .disp_rdy_j(disp_rdy_j), .disp_rdy_k(disp_rdy_k), .disp_v_j(disp_v_j),
        .disp_v_k(disp_v_k), .disp_q_j(disp_q_j), .disp_q_k(disp_q_k), .issue_stall(issue_stall),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rob(issue_rob),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic rj, rk; logic [31:0] vj, vk; logic [3:0] qj, qk, rob;
        logic [1:0] cv; logic [3:0] t0, t1; logic [31:0] d0, d1;
        logic ev; logic [31:0] ers1, ers2;
    } vec_t;

    typedef struct {
        logic [TYPE_W-1:0] typ; logic [31:0] pc, imm; logic [3:0] rob;
        logic rj, rk; logic [31:0] vj, vk; logic [3:0] qj, qk;
    } ent_t;

    vec_t tbl [8];
    ent_t mq [$];
    ent_t m_is;
    logic m_valid;
    int   cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0; cdb_valid = 2'b00; issue_stall = 1'b0;
        flush_in = 1'b0; rdy_in = 1'b1;
    endtask

    task automatic disp(input logic rj, input logic rk, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] rob);
        disp_valid = 1'b1; disp_rdy_j = rj; disp_rdy_k = rk; disp_v_j = vj; disp_v_k = vk;
        disp_q_j = qj; disp_q_k = qk; disp_rob = rob;
        disp_type = TYPE_W'(rob); disp_pc = 32'h1000 + {28'd0, rob}; disp_imm = {28'd0, rob} * 32'd3;
    endtask

    task automatic reset_dut();
        idle();
        rst_n_in = 1'b0;
        tick(); tick();
        rst_n_in = 1'b1;
        mq.delete(); m_valid = 1'b0;
        m_is = '{6'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 4'd0};
    endtask

    function automatic logic [32:0] model_lookup(input logic [3:0] tag);
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid[c] && cdb_rob[c*4 +: 4] == tag) return {1'b1, cdb_value[c*32 +: 32]};
        end
        return 33'd0;
    endfunction

    // Queue model: queue order is age order, head is oldest.
    task automatic model_step();
        int sel, n0;
        logic [32:0] r;
        ent_t e;
        if (flush_in) begin mq.delete(); m_valid = 1'b0; return; end
        if (!rdy_in) return;
        n0  = mq.size();
        sel = -1;
        for (int i = 0; i < mq.size(); i++) if (sel < 0 && mq[i].rj && mq[i].rk) sel = i;
        if (!issue_stall || !m_valid) begin
            m_valid = (sel >= 0);
            if (sel >= 0) m_is = mq[sel];
        end else sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            r = model_lookup(e.qj);
            if (!e.rj && r[32]) begin e.rj = 1'b1; e.vj = r[31:0]; end
            r = model_lookup(e.qk);
            if (!e.rk && r[32]) begin e.rk = 1'b1; e.vk = r[31:0]; end
            mq[i] = e;
        end
        if (sel >= 0) mq.delete(sel);
        if (disp_valid && n0 < DEPTH) begin
            e = '{disp_type, disp_pc, disp_imm, disp_rob, disp_rdy_j, disp_rdy_k, disp_v_j, disp_v_k, disp_q_j, disp_q_k};
            r = model_lookup(disp_q_j);
            if (!e.rj && r[32]) begin e.rj = 1'b1; e.vj = r[31:0]; end
            r = model_lookup(disp_q_k);
            if (!e.rk && r[32]) begin e.rk = 1'b1; e.vk = r[31:0]; end
            mq.push_back(e);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        //            rj    rk    vj       vk       qj    qk    rob    cv     t0    t1    d0       d1       ev    ers1     ers2
        tbl[0] = '{1'b1, 1'b1, 32'd5,   32'd7,   4'd0, 4'd0, 4'd3,  2'b00, 4'd0, 4'd0, 32'd0,   32'd0,   1'b1, 32'd5,   32'd7};
        tbl[1] = '{1'b0, 1'b1, 32'd0,   32'd2,   4'd6, 4'd0, 4'd4,  2'b01, 4'd6, 4'd0, 32'd9,   32'd0,   1'b1, 32'd9,   32'd2};
        tbl[2] = '{1'b1, 1'b0, 32'd1,   32'd0,   4'd0, 4'd3, 4'd5,  2'b10, 4'd0, 4'd3, 32'd0,   32'h77,  1'b1, 32'd1,   32'h77};
        tbl[3] = '{1'b0, 1'b0, 32'd0,   32'd0,   4'd8, 4'd8, 4'd6,  2'b01, 4'd8, 4'd0, 32'h55,  32'd0,   1'b1, 32'h55,  32'h55};
        tbl[4] = '{1'b0, 1'b1, 32'd0,   32'd4,   4'd2, 4'd0, 4'd7,  2'b01, 4'd3, 4'd0, 32'hAA,  32'd0,   1'b0, 32'd0,   32'd0};
        tbl[5] = '{1'b0, 1'b1, 32'd0,   32'd3,   4'd5, 4'd0, 4'd8,  2'b11, 4'd5, 4'd5, 32'h10,  32'h20,  1'b1, 32'h10,  32'd3};
        tbl[6] = '{1'b1, 1'b1, 32'h31,  32'h32,  4'd5, 4'd0, 4'd9,  2'b01, 4'd5, 4'd0, 32'h99,  32'd0,   1'b1, 32'h31,  32'h32};
        tbl[7] = '{1'b0, 1'b1, 32'd0,   32'd1,   4'd7, 4'd0, 4'd10, 2'b00, 4'd7, 4'd7, 32'h66,  32'h66,  1'b0, 32'd0,   32'd0};

        disp_rdy_j = 1'b0; disp_rdy_k = 1'b0; disp_v_j = 32'd0; disp_v_k = 32'd0; disp_q_j = 4'd0;
        disp_q_k = 4'd0; disp_rob = 4'd0; disp_type = 6'd0; disp_pc = 32'd0; disp_imm = 32'd0;
        cdb_rob = 8'd0; cdb_value = 64'd0;
        reset_dut();
        chk("reset_valid", {63'd0, issue_valid}, 64'd0);
        chk("reset_full", {63'd0, full_out}, 64'd0);
        chk("reset_rob", {60'd0, issue_rob}, 64'd0);
        chk("reset_rs1", {32'd0, issue_rs1}, 64'd0);

        // Single-op vectors: dispatch with same-cycle CDB, expect issue after the second edge.
        for (int i = 0; i < 8; i++) begin
            idle(); flush_in = 1'b1; tick(); idle();
            disp(tbl[i].rj, tbl[i].rk, tbl[i].vj, tbl[i].vk, tbl[i].qj, tbl[i].qk, tbl[i].rob);
            cdb_valid = tbl[i].cv; cdb_rob = {tbl[i].t1, tbl[i].t0}; cdb_value = {tbl[i].d1, tbl[i].d0};
            tick(); idle();
            chk($sformatf("vec%0d_latency", i), {63'd0, issue_valid}, 64'd0);
            tick();
            chk($sformatf("vec%0d_valid", i), {63'd0, issue_valid}, {63'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_rs1", i), {32'd0, issue_rs1}, {32'd0, tbl[i].ers1});
                chk($sformatf("vec%0d_rs2", i), {32'd0, issue_rs2}, {32'd0, tbl[i].ers2});
                chk($sformatf("vec%0d_rob", i), {60'd0, issue_rob}, {60'd0, tbl[i].rob});
                chk($sformatf("vec%0d_type", i), {58'd0, issue_type}, {58'd0, 2'd0, tbl[i].rob});
                chk($sformatf("vec%0d_pc_imm", i), {issue_pc, issue_imm},
                    {32'h1000 + {28'd0, tbl[i].rob}, {28'd0, tbl[i].rob} * 32'd3});
            end
        end

        // Ready op overtakes a waiting older op; the woken op follows with the CDB value.
        reset_dut();
        disp(1'b0, 1'b1, 32'd0, 32'd1, 4'd2, 4'd0, 4'd1); tick(); idle();
        disp(1'b1, 1'b1, 32'h22, 32'h33, 4'd0, 4'd0, 4'd2); tick(); idle();
        cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd2}; cdb_value = {32'd0, 32'h11}; tick(); idle();
        chk("t2_first_valid", {63'd0, issue_valid}, 64'd1);
        chk("t2_first_rob", {60'd0, issue_rob}, 64'd2);
        tick();
        chk("t2_second_valid", {63'd0, issue_valid}, 64'd1);
        chk("t2_second_rob", {60'd0, issue_rob}, 64'd1);
        chk("t2_second_rs1", {32'd0, issue_rs1}, 64'h11);

        // Older op in a higher index issues before a younger op in index 0.
        reset_dut();
        disp(1'b1, 1'b1, 32'd1, 32'd1, 4'd0, 4'd0, 4'd9); tick();
        disp(1'b0, 1'b1, 32'd0, 32'd2, 4'd4, 4'd0, 4'd10); tick(); idle();
        chk("t3_filler_rob", {60'd0, issue_rob}, 64'd9);
        disp(1'b0, 1'b1, 32'd0, 32'd3, 4'd4, 4'd0, 4'd11); tick(); idle();
        cdb_valid = 2'b10; cdb_rob = {4'd4, 4'd0}; cdb_value = {32'h44, 32'd0}; tick(); idle();
        tick();
        chk("t3_c_first", {60'd0, issue_rob}, 64'd10);
        chk("t3_c_rs1", {32'd0, issue_rs1}, 64'h44);
        tick();
        chk("t3_d_second", {60'd0, issue_rob}, 64'd11);

        // Fill all entries, reject the extra dispatch, then drain in age order.
        reset_dut();
        for (int i = 0; i < DEPTH; i++) begin
            disp(1'b0, 1'b1, 32'd0, i, 4'd15, 4'd0, 4'(i)); tick();
        end
        idle();
        chk("t4_full", {63'd0, full_out}, 64'd1);
        disp(1'b1, 1'b1, 32'd7, 32'd7, 4'd0, 4'd0, 4'd14); tick(); idle();
        chk("t4_still_full", {63'd0, full_out}, 64'd1);
        chk("t4_extra_ignored", {63'd0, issue_valid}, 64'd0);
        cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd15}; cdb_value = {32'd0, 32'hF0}; tick(); idle();
        tick();
        chk("t4_first_rob", {60'd0, issue_rob}, 64'd0);
        chk("t4_full_clear", {63'd0, full_out}, 64'd0);
        cnt = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (issue_valid) begin
                chk("t4_order", {60'd0, issue_rob}, cnt);
                cnt++;
            end
        end
        chk("t4_issue_count", cnt, 64'd16);

        // Stall holds the issue registers; flush during the stall clears everything.
        reset_dut();
        disp(1'b1, 1'b1, 32'hA, 32'hB, 4'd0, 4'd0, 4'd5); tick();
        disp(1'b1, 1'b1, 32'hC, 32'hD, 4'd0, 4'd0, 4'd6); tick(); idle();
        chk("t6_valid", {63'd0, issue_valid}, 64'd1);
        issue_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_stall_valid", {63'd0, issue_valid}, 64'd1);
            chk("t6_stall_hold", {28'd0, issue_rob, issue_rs1}, {28'd0, 4'd5, 32'hA});
        end
        flush_in = 1'b1; tick(); idle();
        chk("t6_flush_valid", {63'd0, issue_valid}, 64'd0);
        chk("t6_flush_full", {63'd0, full_out}, 64'd0);
        tick();
        chk("t6_flushed_entry_gone", {63'd0, issue_valid}, 64'd0);

        // A dispatch while rdy_in is low is dropped.
        disp(1'b1, 1'b1, 32'd1, 32'd2, 4'd0, 4'd0, 4'd3); rdy_in = 1'b0; tick(); idle();
        tick();
        chk("t7_hold_drop", {63'd0, issue_valid}, 64'd0);

        // Randomized traffic against the queue model.
        reset_dut();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy_in      = ($urandom_range(0, 9) != 0);
            flush_in    = ($urandom_range(0, 49) == 0);
            issue_stall = ($urandom_range(0, 3) == 0);
            disp_valid  = ($urandom_range(0, 1) == 1);
            disp_rdy_j  = ($urandom_range(0, 1) == 1);
            disp_rdy_k  = ($urandom_range(0, 1) == 1);
            disp_v_j    = $urandom; disp_v_k = $urandom;
            disp_q_j    = 4'($urandom_range(0, 7)); disp_q_k = 4'($urandom_range(0, 7));
            disp_rob    = 4'($urandom_range(0, 15)); disp_type = 6'($urandom_range(0, 63));
            disp_pc     = $urandom; disp_imm = $urandom;
            cdb_valid   = 2'($urandom_range(0, 3));
            cdb_rob     = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            cdb_value   = {$urandom, $urandom};
            model_step();
            tick();
            chk("rnd_full", {63'd0, full_out}, {63'd0, (mq.size() == DEPTH)});
            chk("rnd_valid", {63'd0, issue_valid}, {63'd0, m_valid});
            chk("rnd_rs", {issue_rs1, issue_rs2}, {m_is.vj, m_is.vk});
            chk("rnd_pc_imm", {issue_pc, issue_imm}, {m_is.pc, m_is.imm});
            chk("rnd_rob_type", {54'd0, issue_type, issue_rob}, {54'd0, m_is.typ, m_is.rob});
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
